// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states, iteration count and a small magnitude helper.
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide (MIPS HI/LO style), one bit per
// cycle on a single shared 33-bit adder, fixed 34-cycle latency.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        acc_q, acc_d;
  logic [31:0]        opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               signed_op;
  logic               in_sa, in_sb;
  logic [31:0]        mag_a, mag_b;
  logic [32:0]        add_x, add_y, add_sum;
  logic [63:0]        prod_fix;
  logic [31:0]        quot_fix, rem_fix;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign in_sa     = signed_op && a[31];
  assign in_sb     = signed_op && b[31];
  assign mag_a     = in_sa ? abs32(a) : a;
  assign mag_b     = in_sb ? abs32(b) : b;

  // Multiply: acc[63:32] + multiplicand. Divide: (rem<<1 | next bit) - divisor,
  // done as add of the inverted divisor with carry-in; sum[32]=1 means borrow.
  assign add_x   = is_div_q ? acc_q[63:31] : {1'b0, acc_q[63:32]};
  assign add_y   = is_div_q ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
  assign add_sum = add_x + add_y + {32'd0, is_div_q};

  assign prod_fix = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
  assign quot_fix = dz_q ? 32'hFFFF_FFFF
                         : ((sa_q ^ sb_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
  assign rem_fix  = sa_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          is_div_d = op[1];
          sa_d     = in_sa;
          sb_d     = in_sb;
          dz_d     = op[1] && (b == 32'd0);
          // Low half of acc holds the bits consumed LSB-first (multiply)
          // or MSB-first (divide); opnd is the adder's second operand.
          acc_d    = {32'd0, op[1] ? mag_a : mag_b};
          opnd_d   = op[1] ? mag_b : mag_a;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            acc_d = add_sum[32] ? {acc_q[62:0], 1'b0}
                                : {add_sum[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = acc_q[0] ? {add_sum, acc_q[31:1]}
                             : {1'b0, acc_q[63:1]};
          end
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, busy width,
// cancel, ignored restart and asynchronous reset behaviour.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        done;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .hi_o   (hi_o),
    .lo_o   (lo_o),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One full operation: start in cycle 0, expect done in cycle 34, busy for 33.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input bit rel_rst);
    logic [63:0] prev;
    int lat;
    int busy_n;
    bit seen;
    bit moved;
    prev   = {hi_o, lo_o};
    lat    = 0;
    busy_n = 0;
    seen   = 0;
    moved  = 0;
    @(negedge clk);
    if (rel_rst) rst = 1'b0;
    start = 1'b1; op = o; a = av; b = bv;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        seen = 1;
        lat  = i;
      end else if ({hi_o, lo_o} != prev) begin
        moved = 1;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd34);
    chk({tag, "_busycyc"}, 64'(busy_n), 64'd33);
    chk({tag, "_hold"}, {63'd0, moved}, 64'd0);
    chk({tag, "_hi"}, {32'd0, hi_o}, {32'd0, eh});
    chk({tag, "_lo"}, {32'd0, lo_o}, {32'd0, el});
    @(negedge clk);
    chk({tag, "_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] prev;
    int n_done;
    int lat;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);

    // First start lands in the same cycle reset is released.
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_dz",   OP_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
    run_op("div_dz",    OP_DIV,   32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("divu_big",  OP_DIVU,  32'hFFFF_FFFF, 32'd10,       32'h0000_0005, 32'h1999_9999, 1'b0);
    run_op("div_rneg",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);

    // Start together with cancel in IDLE must not launch anything.
    prev = {hi_o, lo_o};
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    chk("cs_busy", {63'd0, busy}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("cs_nodone", 64'(n_done), 64'd0);
    chk("cs_hilo", {hi_o, lo_o}, prev);

    // MULTU 9*9 cancelled on RUN cycle 10.
    prev = {hi_o, lo_o};
    n_done = 0;
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) n_done++;
      if (i == 10) cancel = 1'b1;
    end
    @(negedge clk); cancel = 1'b0;
    chk("cxl_busy", {63'd0, busy}, 64'd0);
    chk("cxl_hilo", {hi_o, lo_o}, prev);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("cxl_nodone", 64'(n_done), 64'd0);
    run_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // A second start during RUN is dropped, not queued.
    n_done = 0;
    lat    = 0;
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (done) begin
        n_done++;
        if (lat == 0) lat = i;
      end
    end
    chk("rs_ndone", 64'(n_done), 64'd1);
    chk("rs_lat", 64'(lat), 64'd34);
    chk("rs_lo", {32'd0, lo_o}, 64'd12);

    // Reset on RUN cycle 20 clears outputs without waiting for a clock edge.
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("arst_hilo", {hi_o, lo_o}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("arst_nodone", 64'(n_done), 64'd0);
    chk("arst_busy2", {63'd0, busy}, 64'd0);
    run_op("divu_after", OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst, asynchronous and active-high.
REQ-002 The block SHALL expose these ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  async active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  multiplicand or dividend (rs).
- b  in  32  multiplier or divisor (rt).
- cancel  in  1  abort the current operation (exception/flush).
- busy  out  1  operation in progress; pipeline stall request.
- hi_o  out  32  result HI: product[63:32] or remainder.
- lo_o  out  32  result LO: product[31:0] or quotient.
- done  out  1  one-cycle result-valid pulse; drives the HI/LO register write enable.

Function
REQ-003 The state machine SHALL have three states: IDLE, RUN and FIN.
REQ-004 In IDLE with start=1 and cancel=0, the block SHALL latch |a|, |b| (signed ops) or a, b (unsigned ops) and record sign flags and op, then enter RUN; busy SHALL be 1 from the next cycle.
REQ-005 RUN SHALL last exactly 32 cycles, with one iteration per cycle counted by a 5-bit counter; counter wrap 31->0 SHALL move the machine to FIN.
REQ-006 Multiply SHALL use radix-2 shift-add on a 33-bit adder into a 64-bit accumulator.
REQ-007 Divide SHALL use restoring shift-subtract on a 33-bit subtractor, producing a 32-bit quotient and a 32-bit remainder.
REQ-008 In FIN, signed results SHALL be corrected as follows: product negated if sa^sb; quotient negated if sa^sb; remainder negated if sa.
REQ-009 At the edge leaving FIN, hi_o/lo_o SHALL load the final result, done SHALL go to 1 for exactly one cycle, busy SHALL drop and the state SHALL return to IDLE.
REQ-010 Latency SHALL be fixed: done is high in the 34th cycle after the cycle in which start was accepted.
REQ-011 hi_o/lo_o SHALL hold their values between done pulses and SHALL never change while done=0.
REQ-012 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-013 Divide by zero SHALL produce lo_o=0xFFFFFFFF and hi_o=a (original dividend) for both DIV and DIVU, with normal latency.
REQ-014 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce lo_o=0x80000000 and hi_o=0x00000000.
REQ-015 cancel=1 in RUN or FIN SHALL return the machine to IDLE at the next edge, with no done pulse, hi_o/lo_o unchanged and busy=0.
REQ-016 cancel and start both high in IDLE SHALL leave the machine in IDLE; cancel wins.
REQ-017 The earliest new start after done or cancel SHALL be in the cycle in which busy=0.

Reset
REQ-018 rst=1 SHALL immediately force state=IDLE, counter=0, busy=0, done=0, hi_o=0 and lo_o=0, independent of clk.
REQ-019 Reset asserted mid-operation SHALL discard the operation with no done pulse after release.
REQ-020 The first start SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-021 Package muldiv_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state encodings (IDLE, RUN, FIN) and ITER=32.
REQ-022 The block SHALL be one module with no sub-module, and the 33-bit adder/subtractor SHALL be shared between multiply and divide.
REQ-023 All outputs SHALL be registered, so that a downstream negedge-written HI/LO register sees stable data and enable.

Verification
REQ-024 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 cycles after start, hi_o=0xFFFFFFFE, lo_o=0x00000001, busy high 33 cycles.
REQ-025 MULT a=0xFFFFFFFD (-3) b=5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; then DIV a=0xFFFFFFF9 (-7) b=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-026 DIVU a=100 b=0 -> lo_o=0xFFFFFFFF, hi_o=0x00000064; DIV a=0x80000000 b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-027 MULTU 9*9, then cancel on RUN cycle 10 -> no done, hi_o/lo_o keep prior values, busy=0 next cycle; then MULTU 6*7 -> hi_o=0, lo_o=42.
REQ-028 start pulsed again on RUN cycle 5 -> ignored, exactly one done; rst asserted on RUN cycle 20 -> outputs 0 immediately, no done after release.
